// File: rtl/tiered_cache_level_if.sv
// Bundle of the upstream request/response and downstream memory signals of
// one cache level.
//   Requester drives: load, store, address, data_in, mem_data, mem_ready
//   Cache drives:     hit, miss, busy, data_out, mem_read, mem_write,
//                     mem_write_data
interface tiered_cache_level_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  load;
    logic                  store;
    logic [31:0]           address;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  mem_ready;
    logic                  hit;
    logic                  miss;
    logic                  mem_write;
    logic                  mem_read;
    logic                  busy;
    logic [DATA_WIDTH-1:0] data_out;
    logic [DATA_WIDTH-1:0] mem_write_data;

    modport master (
        output load, store, address, data_in, mem_data, mem_ready,
        input  hit, miss, mem_write, mem_read, busy, data_out,
               mem_write_data
    );

    modport slave (
        input  load, store, address, data_in, mem_data, mem_ready,
        output hit, miss, mem_write, mem_read, busy, data_out,
               mem_write_data
    );
endinterface

// File: rtl/tiered_cache_level.sv
// Two-way set-associative, write-through, write-allocate cache level with
// one word per line; the same block serves as L1 or L2.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of tiered_cache_level_if (requests, responses,
//                next-level read/write handshake)
module tiered_cache_level #(
    parameter int DATA_WIDTH = 32,
    parameter int SET_WIDTH  = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    tiered_cache_level_if.slave bus
);
    localparam int SETS  = 1 << SET_WIDTH;
    localparam int TAG_W = 30 - SET_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WRITE
    } state_e;

    state_e                state_q, state_d;

    logic [SETS-1:0]       valid_q [2];
    logic [SETS-1:0]       valid_d [2];
    logic [SETS-1:0]       lru_q, lru_d;
    logic [TAG_W-1:0]      tag_q  [2][SETS];
    logic [DATA_WIDTH-1:0] data_q [2][SETS];

    logic [SET_WIDTH-1:0]  fill_idx_q, fill_idx_d;
    logic [TAG_W-1:0]      fill_tag_q, fill_tag_d;
    logic                  fill_way_q, fill_way_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic [SET_WIDTH-1:0]  idx;
    logic [TAG_W-1:0]      tag;
    logic                  hit0, hit1, any_hit, hit_way;
    logic                  victim_way, lookup;
    logic [DATA_WIDTH-1:0] hit_data;

    logic                  wr_en, wr_way;
    logic [SET_WIDTH-1:0]  wr_idx;
    logic [TAG_W-1:0]      wr_tag;
    logic [DATA_WIDTH-1:0] wr_data;

    // Word granularity: byte offset bits take no part in the lookup.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.address[1:0];

    always_comb begin
        idx      = bus.address[SET_WIDTH+1:2];
        tag      = bus.address[31:SET_WIDTH+2];
        hit0     = valid_q[0][idx] && (tag_q[0][idx] == tag);
        hit1     = valid_q[1][idx] && (tag_q[1][idx] == tag);
        any_hit  = hit0 || hit1;
        hit_way  = hit1;
        hit_data = hit1 ? data_q[1][idx] : data_q[0][idx];
        // Invalid ways fill first, way0 before way1; otherwise LRU.
        if (!valid_q[0][idx])
            victim_way = 1'b0;
        else if (!valid_q[1][idx])
            victim_way = 1'b1;
        else
            victim_way = lru_q[idx];
        // rst_n gating keeps hit/miss low while reset is held.
        lookup = rst_n && (state_q == IDLE) && (bus.load || bus.store);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.store)
                    state_d = WRITE;
                else if (bus.load && !any_hit)
                    state_d = FETCH;
            end
            FETCH: if (bus.mem_ready) state_d = IDLE;
            WRITE: if (bus.mem_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.hit            = lookup && any_hit;
        bus.miss           = lookup && !any_hit;
        bus.mem_read       = (state_q == FETCH);
        bus.mem_write      = (state_q == WRITE);
        bus.busy           = (state_q != IDLE);
        bus.mem_write_data = wdata_q;
        if (lookup && bus.load && !bus.store && any_hit)
            bus.data_out = hit_data;
        else
            bus.data_out = data_out_q;
    end

    always_comb begin
        valid_d    = valid_q;
        lru_d      = lru_q;
        fill_idx_d = fill_idx_q;
        fill_tag_d = fill_tag_q;
        fill_way_d = fill_way_q;
        data_out_d = data_out_q;
        wdata_d    = wdata_q;
        wr_en      = 1'b0;
        wr_way     = 1'b0;
        wr_idx     = idx;
        wr_tag     = tag;
        wr_data    = bus.data_in;
        if (state_q == IDLE && bus.store) begin
            wr_en      = 1'b1;
            wr_way     = any_hit ? hit_way : victim_way;
            lru_d[idx] = ~wr_way;
            wdata_d    = bus.data_in;
        end else if (state_q == IDLE && bus.load) begin
            if (any_hit) begin
                lru_d[idx] = ~hit_way;
            end else begin
                fill_idx_d = idx;
                fill_tag_d = tag;
                fill_way_d = victim_way;
            end
        end else if (state_q == FETCH && bus.mem_ready) begin
            wr_en             = 1'b1;
            wr_way            = fill_way_q;
            wr_idx            = fill_idx_q;
            wr_tag            = fill_tag_q;
            wr_data           = bus.mem_data;
            lru_d[fill_idx_q] = ~fill_way_q;
            data_out_d        = bus.mem_data;
        end
        if (wr_en)
            valid_d[wr_way][wr_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q[0] <= '0;
            valid_q[1] <= '0;
            lru_q      <= '0;
            fill_idx_q <= '0;
            fill_tag_q <= '0;
            fill_way_q <= 1'b0;
            data_out_q <= '0;
            wdata_q    <= '0;
        end else begin
            valid_q    <= valid_d;
            lru_q      <= lru_d;
            fill_idx_q <= fill_idx_d;
            fill_tag_q <= fill_tag_d;
            fill_way_q <= fill_way_d;
            data_out_q <= data_out_d;
            wdata_q    <= wdata_d;
        end
    end

    // Tag/data arrays need no reset: valid bits qualify every entry.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_way][wr_idx]  <= wr_tag;
            data_q[wr_way][wr_idx] <= wr_data;
        end
    end
endmodule

// File: tb/tb_tiered_cache_level.sv
// Directed self-checking bench for tiered_cache_level (SET_WIDTH=5).
// Drives the master side of the interface and checks every response.
module tb_tiered_cache_level;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    tiered_cache_level_if #(.DATA_WIDTH(32)) bus ();

    tiered_cache_level #(
        .DATA_WIDTH(32),
        .SET_WIDTH (5)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [31:0] addr, input logic [31:0] d);
        bus.address = addr;
        bus.load    = 1'b1;
        #1;
        check("fill_miss", 32'(bus.miss), 32'd1);
        step();
        check("fill_mem_read", 32'(bus.mem_read), 32'd1);
        bus.mem_data  = d;
        bus.mem_ready = 1'b1;
        step();
        bus.mem_ready = 1'b0;
        check("fill_hit", 32'(bus.hit), 32'd1);
        check("fill_data", bus.data_out, d);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.load      = 1'b0;
        bus.store     = 1'b0;
        bus.address   = '0;
        bus.data_in   = '0;
        bus.mem_data  = '0;
        bus.mem_ready = 1'b0;
        #12;
        check("rst_hit", 32'(bus.hit), 32'd0);
        check("rst_miss", 32'(bus.miss), 32'd0);
        check("rst_mem_read", 32'(bus.mem_read), 32'd0);
        check("rst_mem_write", 32'(bus.mem_write), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_data_out", bus.data_out, 32'd0);
        check("rst_wdata", bus.mem_write_data, 32'd0);
        rst_n = 1'b1;

        // Load miss, two FETCH cycles, then hit on the refilled line.
        bus.address = 32'h100;
        bus.load    = 1'b1;
        #1;
        check("ld100_miss", 32'(bus.miss), 32'd1);
        check("ld100_hit", 32'(bus.hit), 32'd0);
        step();
        check("fetch_mem_read", 32'(bus.mem_read), 32'd1);
        check("fetch_busy", 32'(bus.busy), 32'd1);
        check("fetch_no_miss", 32'(bus.miss), 32'd0);
        step();
        check("fetch_wait", 32'(bus.mem_read), 32'd1);
        bus.mem_data  = 32'hDEADBEEF;
        bus.mem_ready = 1'b1;
        step();
        bus.mem_ready = 1'b0;
        check("refill_busy", 32'(bus.busy), 32'd0);
        check("refill_mem_read", 32'(bus.mem_read), 32'd0);
        check("refill_hit", 32'(bus.hit), 32'd1);
        check("refill_data", bus.data_out, 32'hDEADBEEF);
        step();
        bus.address = 32'h101;
        #1;
        check("alias_hit", 32'(bus.hit), 32'd1);
        check("alias_data", bus.data_out, 32'hDEADBEEF);

        // Store miss with a slow next level.
        bus.load    = 1'b0;
        bus.store   = 1'b1;
        bus.address = 32'h200;
        bus.data_in = 32'h12345678;
        #1;
        check("st200_miss", 32'(bus.miss), 32'd1);
        step();
        bus.store   = 1'b0;
        bus.data_in = 32'h0;
        check("wr_mem_write", 32'(bus.mem_write), 32'd1);
        check("wr_wdata", bus.mem_write_data, 32'h12345678);
        check("wr_busy", 32'(bus.busy), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("wr_hold_busy", 32'(bus.busy), 32'd1);
        end
        bus.mem_ready = 1'b1;
        step();
        bus.mem_ready = 1'b0;
        check("wr_done_busy", 32'(bus.busy), 32'd0);
        check("wr_done_mem_write", 32'(bus.mem_write), 32'd0);
        bus.load    = 1'b1;
        bus.address = 32'h200;
        #1;
        check("ld200_hit", 32'(bus.hit), 32'd1);
        check("ld200_data", bus.data_out, 32'h12345678);
        step();
        check("ld200_no_read", 32'(bus.mem_read), 32'd0);
        bus.address = 32'h100;
        #1;
        check("ld100_way0_kept", bus.data_out, 32'hDEADBEEF);
        step();

        // load+store together: store wins.
        bus.store     = 1'b1;
        bus.address   = 32'h40;
        bus.data_in   = 32'hCAFEF00D;
        bus.mem_ready = 1'b1;
        #1;
        check("ldst_miss", 32'(bus.miss), 32'd1);
        step();
        bus.load  = 1'b0;
        bus.store = 1'b0;
        check("ldst_mem_write", 32'(bus.mem_write), 32'd1);
        check("ldst_no_read", 32'(bus.mem_read), 32'd0);
        step();
        bus.mem_ready = 1'b0;
        check("ldst_idle", 32'(bus.busy), 32'd0);
        check("ldst_no_read2", 32'(bus.mem_read), 32'd0);
        bus.load = 1'b1;
        #1;
        check("ld40_hit", 32'(bus.hit), 32'd1);
        check("ld40_data", bus.data_out, 32'hCAFEF00D);

        // Reset while in FETCH.
        bus.address = 32'h300;
        #1;
        check("ld300_miss", 32'(bus.miss), 32'd1);
        step();
        check("ld300_fetch", 32'(bus.mem_read), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_mem_read", 32'(bus.mem_read), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_miss", 32'(bus.miss), 32'd0);
        check("midrst_data_out", bus.data_out, 32'd0);
        #1;
        rst_n = 1'b1;
        #1;
        check("postrst_miss", 32'(bus.miss), 32'd1);
        bus.load = 1'b0;
        #1;

        // LRU eviction in set 0.
        fill(32'h000, 32'hA0A0A0A0);
        fill(32'h080, 32'hB0B0B0B0);
        bus.address = 32'h000;
        #1;
        check("lru_hit000", 32'(bus.hit), 32'd1);
        step();
        fill(32'h100, 32'h11111111);
        bus.address = 32'h000;
        #1;
        check("evict_hit000", 32'(bus.hit), 32'd1);
        check("evict_data000", bus.data_out, 32'hA0A0A0A0);
        step();
        bus.address = 32'h080;
        #1;
        check("evict_miss080", 32'(bus.miss), 32'd1);
        bus.load = 1'b0;
        #1;
        check("reg_data_out", bus.data_out, 32'h11111111);
        check("idle_no_read", 32'(bus.mem_read), 32'd0);
        step();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/tiered_cache_level.md
Name: tiered_cache_level

Overview:
- Parameterised two-way set-associative, write-through, write-allocate cache level with one 32-bit word per line.
- It is the common building block for the L1 and L2 levels of the memory hierarchy.
- The upstream side takes load/store requests from the core (or from the cache level above).
- The downstream side issues single-word reads and writes to the next level. The next level shares the same address and signals completion with mem_ready.

Parameters:
- DATA_WIDTH, 32, word and line data width in bits.
- SET_WIDTH, 5, log2 of the number of sets (L1 uses 5, L2 uses 6).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- load  input  1  read request, held by the requester until it is serviced.
- store  input  1  write request, held by the requester until it is serviced.
- address  input  32  byte address of the request.
- data_in  input  DATA_WIDTH  store data.
- mem_data  input  DATA_WIDTH  read data from the next level.
- mem_ready  input  1  next level is idle and its data or write is complete.
- hit  output  1  lookup hit (combinational).
- miss  output  1  lookup miss (combinational).
- mem_write  output  1  write-through request to the next level.
- mem_read  output  1  refill request to the next level.
- busy  output  1  cache is in a non-IDLE state.
- data_out  output  DATA_WIDTH  load result.
- mem_write_data  output  DATA_WIDTH  data for the next level; always equals the captured store data.

Behaviour:
- Address split:
  - index = address[SET_WIDTH+1:2]
  - tag = address[31:SET_WIDTH+2]
  - address[1:0] is ignored (word granularity).
- Storage per set:
  - 2 ways, each holding valid, tag and data.
  - One LRU bit per set, naming the way to evict next.
- Victim selection: first invalid way (way0 before way1); otherwise the LRU way.
- Reset (asynchronous, rst_n=0):
  - state=IDLE; all valid bits and LRU bits cleared.
  - hit, miss, mem_read, mem_write and busy are 0.
  - data_out and mem_write_data are 0.
- State machine: IDLE, FETCH, WRITE.
- hit and miss are combinational and are valid only in IDLE while load or store is asserted.
  - hit=1 when some valid way's tag matches; miss=1 when the request is not a hit.
  - Both are 0 when there is no request or the state is not IDLE.
  - They are never both 1.
- store has priority when load and store are asserted together.
- IDLE with load hit:
  - data_out shows the matching way's data combinationally in the same cycle.
  - At the clock edge, LRU is set to the other way; the state stays IDLE.
- IDLE with load miss: at the clock edge, the index, tag and victim way are latched and the state goes to FETCH.
- FETCH:
  - mem_read=1 and busy=1.
  - At the first edge where mem_ready=1, the victim line is written with mem_data, valid=1 and the latched tag.
  - At the same edge, LRU points away from the filled way, data_out is registered with mem_data, and the state returns to IDLE.
  - The requester's still-asserted load then hits on the next cycle.
- IDLE with store (hit or miss):
  - At the clock edge, the matching way (or the victim way on a miss) is written with data_in, valid=1 and the tag.
  - At the same edge, LRU is updated, data_in is latched into mem_write_data, and the state goes to WRITE.
- WRITE:
  - mem_write=1 and busy=1.
  - The state stays in WRITE until an edge with mem_ready=1, then returns to IDLE.
- Minimum occupancy: FETCH and WRITE each last at least 1 cycle. mem_ready is sampled only while in those states.
- Request handling outside IDLE: load and store changes are ignored outside IDLE, and no new lookup occurs until IDLE.
- Cache lines are never dirty, so no write-back is ever required.
- Reset mid-operation: an abandoned FETCH leaves no line written; an abandoned WRITE still has its line updated. mem_read and mem_write drop immediately on reset.
- Aliasing: two addresses differing only in bits [1:0] map to the same line.

Test Plan:
- After reset, load of 0x100 -> miss=1, then FETCH with mem_read=1 and busy=1. With mem_ready=1 and mem_data=0xDEADBEEF, one cycle later IDLE, hit=1 and data_out=0xDEADBEEF.
- Store data_in=0x12345678 to 0x200 -> next cycle mem_write=1 and mem_write_data=0x12345678; mem_ready held 0 for 3 cycles keeps busy=1; then IDLE. A subsequent load of 0x200 hits with 0x12345678 and no mem_read.
- Fill addresses 0x000 and 0x080 (same set for SET_WIDTH=5), then load 0x000 (hit), then miss 0x100. The refill evicts the 0x080 line; load 0x000 still hits and load 0x080 misses.
- load and store asserted together to 0x40 -> treated as a store: a WRITE cycle, and mem_read is never asserted.
- Assert rst_n=0 during FETCH -> outputs go to 0 at once; after release, load of the same address misses again.
- Load 0x101 after a fill of 0x100 -> hit with the same data (byte offset ignored).
